breakout_pio_in: RTL

Avalon-MM input PIO for the breakout design: samples up to WIDTH external inputs (push-buttons, switches), synchronises and debounces them, records selected edges in a sticky edge-capture register, and raises a maskable level interrupt to the Nios II. It is the input-side counterpart of the design's output PIO and sits on the same system interconnect, using the same 2-bit word-address register window and zero-wait-state read/write timing.

---
 rtl/breakout_pio_pkg.sv | 25 ++
 rtl/breakout_pio_in_if.sv | 23 ++
 rtl/breakout_debounce.sv | 54 +++++
 rtl/breakout_pio_in.sv | 78 +++++++
 4 files changed

// File: rtl/breakout_pio_pkg.sv
// Shared register-map and edge-type constants for the breakout input PIO.
// Pure definitions: no latency, no flow control.
package breakout_pio_pkg;

  localparam logic [1:0] ADDR_DATA     = 2'd0;
  localparam logic [1:0] ADDR_RSVD     = 2'd1;
  localparam logic [1:0] ADDR_IRQ_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE_CAP = 2'd3;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  // True when an accepted transition to new_level should be recorded.
  function automatic logic edge_qualifies(input int edge_type, input logic new_level);
    logic q;
    case (edge_type)
      EDGE_RISE: q = new_level;
      EDGE_FALL: q = ~new_level;
      default:   q = 1'b1;
    endcase
    return q;
  endfunction

endpackage

// File: rtl/breakout_pio_in_if.sv
// Avalon-MM slave bus plus external input pins of the breakout input PIO.
// Zero-wait-state: reads are combinational, writes commit on the next clk edge; never stalls.
interface breakout_pio_in_if #(
  parameter int WIDTH = 8
);
  logic [1:0]       address;
  logic             chipselect;
  logic             write_n;
  logic [31:0]      writedata;
  logic [31:0]      readdata;
  logic [WIDTH-1:0] in_port;
  logic             irq;

  modport master (
    output address, chipselect, write_n, writedata, in_port,
    input  readdata, irq
  );

  modport slave (
    input  address, chipselect, write_n, writedata, in_port,
    output readdata, irq
  );
endinterface

// File: rtl/breakout_debounce.sv
// One-bit synchroniser + debouncer; accept pulse is combinational in the cycle before stable updates.
// Latency SYNC_STAGES + DEBOUNCE_CYCLES clk edges from pin change to stable; no backpressure.
module breakout_debounce #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic d_in,
  output logic stable,
  output logic accept_vld,
  output logic accept_dat
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   stable_q, stable_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   sync;

  always_comb begin
    sync_d     = {sync_q[SYNC_STAGES-2:0], d_in};
    sync       = sync_q[SYNC_STAGES-1];
    stable_d   = stable_q;
    cnt_d      = cnt_q;
    accept_vld = 1'b0;
    accept_dat = sync;
    if (sync == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      // The new level has persisted long enough: take it and report the accept.
      stable_d   = sync;
      cnt_d      = '0;
      accept_vld = 1'b1;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q   <= '0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync_q   <= sync_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable = stable_q;
endmodule

// File: rtl/breakout_pio_in.sv
// Avalon-MM input PIO: debounced DATA, IRQ_MASK, sticky W1C EDGE_CAP and a level irq.
// Reads combinational, writes on next clk edge; edges recorded SYNC_STAGES+DEBOUNCE_CYCLES after the pin; never stalls.
module breakout_pio_in
  import breakout_pio_pkg::*;
#(
  parameter int WIDTH           = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int EDGE_TYPE       = 0
) (
  input  logic             clk,
  input  logic             reset,
  breakout_pio_in_if.slave bus
);
  logic [WIDTH-1:0] stable, acc_vld, acc_dat, edge_set;
  logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
  logic [WIDTH-1:0] edge_cap_q, edge_cap_d;
  logic [31:0]      rd_word;
  logic             wr_en;
  logic             writedata_unused;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    breakout_debounce #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk       (clk),
      .rst       (reset),
      .d_in      (bus.in_port[i]),
      .stable    (stable[i]),
      .accept_vld(acc_vld[i]),
      .accept_dat(acc_dat[i])
    );
  end

  assign writedata_unused = ^bus.writedata;

  always_comb begin
    wr_en      = bus.chipselect & ~bus.write_n;
    irq_mask_d = irq_mask_q;
    edge_cap_d = edge_cap_q;
    for (int i = 0; i < WIDTH; i++) begin
      edge_set[i] = acc_vld[i] & edge_qualifies(EDGE_TYPE, acc_dat[i]);
    end
    if (wr_en && bus.address == ADDR_IRQ_MASK) begin
      irq_mask_d = bus.writedata[WIDTH-1:0];
    end
    if (wr_en && bus.address == ADDR_EDGE_CAP) begin
      edge_cap_d = edge_cap_q & ~bus.writedata[WIDTH-1:0];
    end
    // OR-ing the new edges last lets a simultaneous set beat the W1C clear.
    edge_cap_d = edge_cap_d | edge_set;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_mask_q <= '0;
      edge_cap_q <= '0;
    end else begin
      irq_mask_q <= irq_mask_d;
      edge_cap_q <= edge_cap_d;
    end
  end

  always_comb begin
    rd_word = '0;
    case (bus.address)
      ADDR_DATA:     rd_word[WIDTH-1:0] = stable;
      ADDR_RSVD:     rd_word = '0;
      ADDR_IRQ_MASK: rd_word[WIDTH-1:0] = irq_mask_q;
      ADDR_EDGE_CAP: rd_word[WIDTH-1:0] = edge_cap_q;
      default:       rd_word = '0;
    endcase
  end

  assign bus.readdata = rd_word;
  assign bus.irq      = |(edge_cap_q & irq_mask_q);
endmodule
